mrd_sink_fmt: RTL and testbench
===============================

Name: mrd_sink_fmt

Overview:
- Input front-end of the mixed-radix DFT core. Sits between the external streaming source and the mrd_mem_top sink path.
- Accepts one streaming sample per handshake, checks sop/eop framing against the latched dftpts, and maps each sample index n to a memory bank (n mod NUM_BANKS) and address (n div NUM_BANKS).
- Drives the sink-side status used by mrd_ctrl_fsm: sink_sop, dftpts, sink_ongoing.

Parameters:
- DW, 18, sample component width.
- NUM_BANKS, 5, number of memory banks; legal range 2..8.
- PTS_MIN, 12, smallest legal dftpts.
- AW, 10, bank address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source sample valid.
- in_sop  in  1  first sample of frame.
- in_eop  in  1  last sample of frame.
- in_real  in  DW  real part.
- in_imag  in  DW  imag part.
- in_dftpts  in  12  DFT size; sampled only on an accepted sop beat.
- in_inverse  in  1  inverse flag; sampled only on an accepted sop beat.
- in_ready  out  1  accepts a beat when high.
- mem_busy  in  1  memory cannot take writes (rd/wr/source phase in progress).
- wr_en  out  1  write strobe.
- wr_bank  out  3  bank index.
- wr_addr  out  AW  bank address.
- wr_real  out  DW  registered sample, real part.
- wr_imag  out  DW  registered sample, imag part.
- stat_sink_sop  out  1  one-cycle pulse, registered with the first write.
- stat_dftpts  out  12  latched frame size.
- stat_inverse  out  1  latched inverse flag.
- stat_sink_ongoing  out  1  high from the first write until the frame_done cycle, inclusive.
- frame_done  out  1  one-cycle pulse when a good frame completes.
- err_len  out  1  one-cycle pulse on a length mismatch.
- err_sop  out  1  one-cycle pulse on a sop received mid-frame.
- err_pts  out  1  one-cycle pulse on an illegal dftpts.

Behaviour:
- Handshake:
  - in_ready = !mem_busy in IDLE and RUN; in_ready = 1 in DISCARD.
  - A beat is accepted when in_valid && in_ready. in_valid may drop between beats (bubbles are allowed).
- Reset: every output is 0; FSM returns to IDLE; counters are cleared. A reset mid-frame drops the frame with no error pulse.
- FSM IDLE:
  - An accepted beat with in_sop=0 is dropped silently.
  - Accepted sop with PTS_MIN <= in_dftpts <= NUM_BANKS*2^AW: latch dftpts and inverse, write sample n=0, go to RUN. If in_eop is also set on that beat, pulse err_len and return to IDLE.
  - Accepted sop with an illegal dftpts: pulse err_pts, go to DISCARD; if in_eop is set on the same beat, stay in IDLE.
- FSM RUN:
  - Each accepted beat writes n = n+1.
  - Bank/address counters: bank increments and wraps to 0 at NUM_BANKS-1; addr increments on each wrap. No divider.
  - Accepted eop at n == dftpts-1: pulse frame_done, go to IDLE.
  - Accepted eop at n < dftpts-1: write the sample, pulse err_len, go to IDLE, no frame_done.
  - Beat n == dftpts-1 without eop: write it, pulse err_len, go to DISCARD.
  - Accepted sop in RUN: pulse err_sop, abort the current frame, restart as if in IDLE (the same beat becomes n=0 of the new frame, same legality rules).
- FSM DISCARD: drop beats until an accepted eop, then go to IDLE. A sop in DISCARD is handled as in IDLE.
- Latency: every write output and status pulse is registered one cycle after the accepting edge.
- wr_en is never asserted while mem_busy was high at acceptance, because in_ready gates acceptance.
- Error priority on the same beat: err_pts > err_sop > err_len.

Optional Feature:
- Macro MRD_SINK_ERRCNT_EN.
- When defined: adds output err_cnt (16 bits) and input err_clr (1 bit).
  - err_cnt increments by the number of error pulses asserted that cycle and saturates at 0xFFFF.
  - err_clr clears it synchronously; a clear wins over a same-cycle increment.
  - Reset value of err_cnt is 0.
- When undefined: neither port nor the counter exists.

Decomposition:
- Package mrd_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DISCARD} sink_state_t;
  - constants MRD_PTS_W = 12 and MRD_DW = 18;
  - typedef struct {bank, addr, real, imag} mrd_wr_t.
- One natural sub-module: mrd_bank_addr_gen, the bank/address wrap counter with clear and increment inputs.

Test Plan:
- 12-point frame, no bubbles, mem_busy=0:
  - Bank sequence is 0,1,2,3,4,0,1,2,3,4,0,1; addr sequence is 0×5, 1×5, 2×2.
  - frame_done pulses exactly one cycle after the eop beat.
- 1200-point frame with random in_valid bubbles and mem_busy toggling: exactly 1200 writes; last write is bank 4, addr 239; frame_done=1.
- Early eop on beat index 7 with dftpts=12: 8 writes, one err_len pulse, no frame_done; the next 12-point frame completes cleanly.
- Missing eop with dftpts=12 and 15 beats sent: 12 writes, err_len on the 12th, 3 beats dropped in DISCARD; in_ready stays 1.
- Sop at beat 5 of a 24-point frame: err_sop pulses and the new frame starts at bank 0, addr 0. Sop with dftpts=8: err_pts pulses and no writes occur.
- Reset asserted at beat 3: all outputs are 0 next cycle; a subsequent sop frame starts at n=0.

Source files
------------

// File: rtl/mrd_pkg.sv
// Shared types and widths for the mixed-radix DFT sink path.
package mrd_pkg;

  localparam int unsigned MRD_PTS_W  = 12;
  localparam int unsigned MRD_DW     = 18;
  localparam int unsigned MRD_AW     = 10;
  localparam int unsigned MRD_BANK_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} sink_state_t;

  // One bank write: bank index, bank address, sample real/imag.
  typedef struct packed {
    logic [MRD_BANK_W-1:0] bank;
    logic [MRD_AW-1:0]     addr;
    logic [MRD_DW-1:0]     re;
    logic [MRD_DW-1:0]     im;
  } mrd_wr_t;

endpackage

// File: rtl/mrd_sink_fmt_if.sv
// Streaming sample source interface feeding mrd_sink_fmt.
interface mrd_sink_fmt_if #(
  parameter int unsigned DW    = 18,
  parameter int unsigned PTS_W = 12
);
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic [DW-1:0]    in_real;
  logic [DW-1:0]    in_imag;
  logic [PTS_W-1:0] in_dftpts;
  logic             in_inverse;
  logic             in_ready;

  modport master (
    output in_valid, in_sop, in_eop, in_real, in_imag, in_dftpts, in_inverse,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_real, in_imag, in_dftpts, in_inverse,
    output in_ready
  );
endinterface

// File: rtl/mrd_bank_addr_gen.sv
// Bank/address wrap counter: bank cycles 0..NUM_BANKS-1, addr advances on each wrap.
module mrd_bank_addr_gen #(
  parameter int unsigned NUM_BANKS = 5,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [2:0]    bank_o,
  output logic [AW-1:0] addr_o
);

  localparam logic [2:0] LastBank = 3'(NUM_BANKS - 1);

  logic [2:0]    bank_q, bank_d, bank_base;
  logic [AW-1:0] addr_q, addr_d, addr_base;

  // clr and inc together means "position after index 0".
  always_comb begin
    bank_base = clr_i ? '0 : bank_q;
    addr_base = clr_i ? '0 : addr_q;
    bank_d    = bank_base;
    addr_d    = addr_base;
    if (inc_i) begin
      if (bank_base == LastBank) begin
        bank_d = '0;
        addr_d = addr_base + 1'b1;
      end else begin
        bank_d = bank_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

  assign bank_o = bank_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/mrd_sink_fmt.sv
// Sink front-end: frames streaming samples, maps index n to bank/addr, reports status.
// Optional error counter enabled by defining MRD_SINK_ERRCNT_EN.
module mrd_sink_fmt
  import mrd_pkg::*;
#(
  parameter int unsigned DW        = 18,
  parameter int unsigned NUM_BANKS = 5,
  parameter int unsigned PTS_MIN   = 12,
  parameter int unsigned AW        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mrd_sink_fmt_if.slave        in_if,
  input  logic                 mem_busy,
  output logic                 wr_en,
  output logic [2:0]           wr_bank,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_real,
  output logic [DW-1:0]        wr_imag,
  output logic                 stat_sink_sop,
  output logic [MRD_PTS_W-1:0] stat_dftpts,
  output logic                 stat_inverse,
  output logic                 stat_sink_ongoing,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_sop,
  output logic                 err_pts
`ifdef MRD_SINK_ERRCNT_EN
  ,
  input  logic                 err_clr,
  output logic [15:0]          err_cnt
`endif
);

  localparam int unsigned PtsMax = NUM_BANKS << AW;

  sink_state_t          state_q, state_d;
  logic [MRD_PTS_W-1:0] n_q, n_d, dftpts_q, dftpts_d;
  logic                 inverse_q, inverse_d;
  logic                 accept, pts_ok, last_beat, start, wr;
  logic [2:0]           gen_bank;
  logic [AW-1:0]        gen_addr;
  mrd_wr_t              wr_q;
  logic                 wr_en_q, sink_sop_q, ongoing_q, ongoing_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_len_q, err_len_d, err_sop_q, err_sop_d, err_pts_q, err_pts_d;

  assign in_if.in_ready = !rst && ((state_q == DISCARD) || !mem_busy);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign pts_ok         = (32'(in_if.in_dftpts) >= PTS_MIN) && (32'(in_if.in_dftpts) <= PtsMax);
  assign last_beat      = (n_q == dftpts_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    dftpts_d     = dftpts_q;
    inverse_d    = inverse_q;
    start        = 1'b0;
    wr           = 1'b0;
    frame_done_d = 1'b0;
    err_len_d    = 1'b0;
    err_sop_d    = 1'b0;
    err_pts_d    = 1'b0;
    if (accept) begin
      if (in_if.in_sop) begin
        // A sop restarts framing from any state; err_pts outranks err_sop.
        err_sop_d = (state_q == RUN) && pts_ok;
        if (pts_ok) begin
          start     = 1'b1;
          wr        = 1'b1;
          dftpts_d  = in_if.in_dftpts;
          inverse_d = in_if.in_inverse;
          n_d       = MRD_PTS_W'(1);
          if (in_if.in_eop) begin
            state_d   = IDLE;
            err_len_d = !err_sop_d;
          end else begin
            state_d = RUN;
          end
        end else begin
          err_pts_d = 1'b1;
          state_d   = in_if.in_eop ? IDLE : DISCARD;
        end
      end else begin
        case (state_q)
          RUN: begin
            wr  = 1'b1;
            n_d = n_q + 1'b1;
            if (in_if.in_eop) begin
              state_d = IDLE;
              if (last_beat) frame_done_d = 1'b1;
              else           err_len_d    = 1'b1;
            end else if (last_beat) begin
              err_len_d = 1'b1;
              state_d   = DISCARD;
            end
          end
          DISCARD: if (in_if.in_eop) state_d = IDLE;
          default: ;
        endcase
      end
    end
    ongoing_d = (state_d == RUN) || frame_done_d;
  end

  mrd_bank_addr_gen #(
    .NUM_BANKS(NUM_BANKS),
    .AW       (AW)
  ) u_bank_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .inc_i (wr),
    .bank_o(gen_bank),
    .addr_o(gen_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      dftpts_q     <= '0;
      inverse_q    <= 1'b0;
      wr_q         <= '0;
      wr_en_q      <= 1'b0;
      sink_sop_q   <= 1'b0;
      ongoing_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_sop_q    <= 1'b0;
      err_pts_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      dftpts_q     <= dftpts_d;
      inverse_q    <= inverse_d;
      wr_en_q      <= wr;
      sink_sop_q   <= start;
      ongoing_q    <= ongoing_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      err_sop_q    <= err_sop_d;
      err_pts_q    <= err_pts_d;
      if (wr) begin
        wr_q.bank <= start ? '0 : gen_bank;
        wr_q.addr <= start ? '0 : gen_addr;
        wr_q.re   <= in_if.in_real;
        wr_q.im   <= in_if.in_imag;
      end
    end
  end

  assign wr_en             = wr_en_q;
  assign wr_bank           = wr_q.bank;
  assign wr_addr           = wr_q.addr;
  assign wr_real           = wr_q.re;
  assign wr_imag           = wr_q.im;
  assign stat_sink_sop     = sink_sop_q;
  assign stat_dftpts       = dftpts_q;
  assign stat_inverse      = inverse_q;
  assign stat_sink_ongoing = ongoing_q;
  assign frame_done        = frame_done_q;
  assign err_len           = err_len_q;
  assign err_sop           = err_sop_q;
  assign err_pts           = err_pts_q;

`ifdef MRD_SINK_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt_q} + 17'(err_len_q) + 17'(err_sop_q) + 17'(err_pts_q);

  always_ff @(posedge clk) begin
    if (rst || err_clr)  err_cnt_q <= '0;
    else if (err_sum[16]) err_cnt_q <= 16'hFFFF;
    else                  err_cnt_q <= err_sum[15:0];
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mrd_sink_fmt.sv
// Scoreboard bench for mrd_sink_fmt: expected writes queued at drive time, popped on wr_en.
module tb_mrd_sink_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy;
  logic        wr_en;
  logic [2:0]  wr_bank;
  logic [9:0]  wr_addr;
  logic [17:0] wr_real, wr_imag;
  logic        stat_sink_sop, stat_inverse, stat_sink_ongoing;
  logic [11:0] stat_dftpts;
  logic        frame_done, err_len, err_sop, err_pts;
`ifdef MRD_SINK_ERRCNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  typedef struct packed {
    logic [2:0]  bank;
    logic [9:0]  addr;
    logic [17:0] re;
    logic [17:0] im;
    logic        sop;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0, failures = 0;
  int  cnt_wr, cnt_done, cnt_len, cnt_sop, cnt_pts, cnt_ssop, total_err;
  int  last_bank, last_addr;

  mrd_sink_fmt_if #(.DW(18), .PTS_W(12)) sif ();

  mrd_sink_fmt dut (
    .clk              (clk),
    .rst              (rst),
    .in_if            (sif),
    .mem_busy         (mem_busy),
    .wr_en            (wr_en),
    .wr_bank          (wr_bank),
    .wr_addr          (wr_addr),
    .wr_real          (wr_real),
    .wr_imag          (wr_imag),
    .stat_sink_sop    (stat_sink_sop),
    .stat_dftpts      (stat_dftpts),
    .stat_inverse     (stat_inverse),
    .stat_sink_ongoing(stat_sink_ongoing),
    .frame_done       (frame_done),
    .err_len          (err_len),
    .err_sop          (err_sop),
    .err_pts          (err_pts)
`ifdef MRD_SINK_ERRCNT_EN
    ,
    .err_clr          (err_clr),
    .err_cnt          (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard/monitor, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t exp_w, got_w;
    if (rst) total_err = 0;
    if (wr_en) begin
      cnt_wr++;
      last_bank = int'(wr_bank);
      last_addr = int'(wr_addr);
      got_w.bank = wr_bank;
      got_w.addr = wr_addr;
      got_w.re   = wr_real;
      got_w.im   = wr_imag;
      got_w.sop  = stat_sink_sop;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got bank=%0d addr=%0d required=no write",
                 wr_bank, wr_addr);
      end else begin
        exp_w = sb_q.pop_front();
        if (got_w !== exp_w) begin
          failures++;
          $display("FAIL sb_write got=%h required=%h", got_w, exp_w);
        end
      end
    end else if (stat_sink_sop) begin
      failures++;
      $display("FAIL sop_without_write got stat_sink_sop=1 required=0");
    end
    cnt_done  += int'(frame_done);
    cnt_len   += int'(err_len);
    cnt_sop   += int'(err_sop);
    cnt_pts   += int'(err_pts);
    cnt_ssop  += int'(stat_sink_sop);
    total_err += int'(err_len) + int'(err_sop) + int'(err_pts);
  end

  task automatic clear_counts();
    cnt_wr = 0; cnt_done = 0; cnt_len = 0; cnt_sop = 0; cnt_pts = 0; cnt_ssop = 0;
  endtask

  task automatic drain();
    mem_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drives one beat until accepted; queues the expected write for index n if exp_wr.
  task automatic send_beat(input bit sop, input bit eop, input logic [11:0] pts,
                           input bit exp_wr, input int n, input int bubble_max,
                           input bit busy_rand);
    sb_t         e;
    logic [17:0] re, im;
    bit          acc;
    int          guard;
    re = 18'($urandom);
    im = 18'($urandom);
    repeat ($urandom_range(0, bubble_max)) begin
      if (busy_rand) mem_busy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if (exp_wr) begin
      e.bank = 3'(n % 5);
      e.addr = 10'(n / 5);
      e.re   = re;
      e.im   = im;
      e.sop  = sop;
      sb_q.push_back(e);
    end
    sif.in_valid   = 1'b1;
    sif.in_sop     = sop;
    sif.in_eop     = eop;
    sif.in_real    = re;
    sif.in_imag    = im;
    sif.in_dftpts  = pts;
    sif.in_inverse = sop;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      if (busy_rand) mem_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = sif.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    sif.in_valid = 1'b0;
    sif.in_sop   = 1'b0;
    sif.in_eop   = 1'b0;
    if (!acc) begin
      failures++;
      $display("FAIL handshake_timeout got in_ready=0 required=1");
    end
  endtask

  task automatic send_clean12();
    for (int i = 0; i < 12; i++) send_beat(i == 0, i == 11, 12'd12, 1'b1, i, 0, 1'b0);
  endtask

  task automatic test_reset();
    logic [65:0] outs;
    rst = 1'b1;
    mem_busy = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_sop   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {wr_en, wr_bank, wr_addr, wr_real, wr_imag, stat_sink_sop, stat_dftpts,
            stat_inverse, stat_sink_ongoing, frame_done, err_len, err_sop, err_pts,
            sif.in_ready};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", outs);
    end
    sif.in_valid = 1'b0;
    sif.in_sop   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (sif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_busy got=%b required=0", sif.in_ready);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle got=%b required=1", sif.in_ready);
    end
  endtask

  task automatic test_frame12();
    clear_counts();
    for (int i = 0; i < 12; i++) send_beat(i == 0, i == 11, 12'd12, 1'b1, i, 0, 1'b0);
    @(negedge clk);
    checks++;
    if ({frame_done, stat_sink_ongoing} !== 2'b11) begin
      failures++;
      $display("FAIL f12_done_pulse got done,ongoing=%b%b required=11",
               frame_done, stat_sink_ongoing);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, stat_sink_ongoing} !== 2'b00) begin
      failures++;
      $display("FAIL f12_done_end got done,ongoing=%b%b required=00",
               frame_done, stat_sink_ongoing);
    end
    drain();
    checks++;
    if (cnt_wr != 12 || cnt_done != 1 || cnt_ssop != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL f12_counts got wr=%0d done=%0d ssop=%0d q=%0d required 12 1 1 0",
               cnt_wr, cnt_done, cnt_ssop, sb_q.size());
    end
    checks++;
    if (stat_dftpts !== 12'd12 || stat_inverse !== 1'b1) begin
      failures++;
      $display("FAIL f12_stat got pts=%0d inv=%b required 12 1", stat_dftpts, stat_inverse);
    end
  endtask

  task automatic test_frame1200();
    clear_counts();
    for (int i = 0; i < 1200; i++) send_beat(i == 0, i == 1199, 12'd1200, 1'b1, i, 2, 1'b1);
    drain();
    checks++;
    if (cnt_wr != 1200 || cnt_done != 1 || (cnt_len + cnt_sop + cnt_pts) != 0) begin
      failures++;
      $display("FAIL f1200_counts got wr=%0d done=%0d errs=%0d required 1200 1 0",
               cnt_wr, cnt_done, cnt_len + cnt_sop + cnt_pts);
    end
    checks++;
    if (last_bank != 4 || last_addr != 239) begin
      failures++;
      $display("FAIL f1200_last got bank=%0d addr=%0d required 4 239", last_bank, last_addr);
    end
  endtask

  task automatic test_early_eop();
    clear_counts();
    for (int i = 0; i < 8; i++) send_beat(i == 0, i == 7, 12'd12, 1'b1, i, 0, 1'b0);
    drain();
    checks++;
    if (cnt_wr != 8 || cnt_len != 1 || cnt_done != 0) begin
      failures++;
      $display("FAIL early_eop got wr=%0d len=%0d done=%0d required 8 1 0",
               cnt_wr, cnt_len, cnt_done);
    end
    clear_counts();
    send_clean12();
    drain();
    checks++;
    if (cnt_wr != 12 || cnt_len != 0 || cnt_done != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL early_eop_next got wr=%0d len=%0d done=%0d required 12 0 1",
               cnt_wr, cnt_len, cnt_done);
    end
  endtask

  task automatic test_missing_eop();
    clear_counts();
    for (int i = 0; i < 12; i++) send_beat(i == 0, 1'b0, 12'd12, 1'b1, i, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (err_len !== 1'b1) begin
      failures++;
      $display("FAIL miss_eop_len got err_len=%b required=1", err_len);
    end
    for (int i = 12; i < 15; i++) begin
      mem_busy = 1'b1;
      #1;
      checks++;
      if (sif.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL discard_ready got=%b required=1", sif.in_ready);
      end
      send_beat(1'b0, 1'b0, 12'd12, 1'b0, i, 0, 1'b0);
    end
    drain();
    checks++;
    if (cnt_wr != 12 || cnt_len != 1 || cnt_done != 0) begin
      failures++;
      $display("FAIL miss_eop got wr=%0d len=%0d done=%0d required 12 1 0",
               cnt_wr, cnt_len, cnt_done);
    end
  endtask

  task automatic test_sop_mid();
    clear_counts();
    for (int i = 0; i < 5; i++) send_beat(i == 0, 1'b0, 12'd24, 1'b1, i, 0, 1'b0);
    send_beat(1'b1, 1'b0, 12'd24, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if ({err_sop, err_len, err_pts} !== 3'b100) begin
      failures++;
      $display("FAIL sop_mid_pulse got sop,len,pts=%b%b%b required=100",
               err_sop, err_len, err_pts);
    end
    for (int i = 1; i < 24; i++) send_beat(1'b0, i == 23, 12'd24, 1'b1, i, 1, 1'b0);
    drain();
    checks++;
    if (cnt_wr != 29 || cnt_sop != 1 || cnt_done != 1 || cnt_ssop != 2 || cnt_len != 0) begin
      failures++;
      $display("FAIL sop_mid got wr=%0d sop=%0d done=%0d ssop=%0d len=%0d req 29 1 1 2 0",
               cnt_wr, cnt_sop, cnt_done, cnt_ssop, cnt_len);
    end
  endtask

  task automatic test_bad_pts();
    clear_counts();
    send_beat(1'b1, 1'b0, 12'd8, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (err_pts !== 1'b1 || err_sop !== 1'b0) begin
      failures++;
      $display("FAIL bad_pts_pulse got pts=%b sop=%b required 1 0", err_pts, err_sop);
    end
    send_beat(1'b0, 1'b0, 12'd8, 1'b0, 1, 0, 1'b0);
    send_beat(1'b0, 1'b1, 12'd8, 1'b0, 2, 0, 1'b0);
    drain();
    checks++;
    if (cnt_wr != 0 || cnt_pts != 1 || cnt_len != 0) begin
      failures++;
      $display("FAIL bad_pts got wr=%0d pts=%0d len=%0d required 0 1 0",
               cnt_wr, cnt_pts, cnt_len);
    end
  endtask

  task automatic test_reset_mid();
    logic [65:0] outs;
    clear_counts();
    for (int i = 0; i < 3; i++) send_beat(i == 0, 1'b0, 12'd12, 1'b1, i, 0, 1'b0);
    sif.in_valid = 1'b1;
    sif.in_real  = 18'h1234;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outs = {wr_en, wr_bank, wr_addr, wr_real, wr_imag, stat_sink_sop, stat_dftpts,
            stat_inverse, stat_sink_ongoing, frame_done, err_len, err_sop, err_pts,
            sif.in_ready};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h required=0", outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sif.in_valid = 1'b0;
    send_clean12();
    drain();
    checks++;
    if (cnt_wr != 15 || cnt_done != 1 || (cnt_len + cnt_sop + cnt_pts) != 0
        || sb_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid got wr=%0d done=%0d errs=%0d q=%0d required 15 1 0 0",
               cnt_wr, cnt_done, cnt_len + cnt_sop + cnt_pts, sb_q.size());
    end
  endtask

`ifdef MRD_SINK_ERRCNT_EN
  task automatic test_err_cnt();
    send_beat(1'b1, 1'b1, 12'd12, 1'b1, 0, 0, 1'b0);
    drain();
    checks++;
    if (int'(err_cnt) != total_err || total_err == 0) begin
      failures++;
      $display("FAIL err_cnt got=%0d required=%0d", err_cnt, total_err);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL err_clr got=%0d required=0", err_cnt);
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    mem_busy       = 1'b0;
    sif.in_valid   = 1'b0;
    sif.in_sop     = 1'b0;
    sif.in_eop     = 1'b0;
    sif.in_real    = '0;
    sif.in_imag    = '0;
    sif.in_dftpts  = '0;
    sif.in_inverse = 1'b0;
`ifdef MRD_SINK_ERRCNT_EN
    err_clr        = 1'b0;
`endif
    clear_counts();
    total_err = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_frame12();
    test_frame1200();
    test_early_eop();
    test_missing_eop();
    test_sop_mid();
    test_bad_pts();
    test_reset_mid();
`ifdef MRD_SINK_ERRCNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
